// File: rtl/fp_issuer_pkg.sv
// fp_issuer_pkg: op codes, FSM states, request record and canonical NaNs for the FP operand issuer
package fp_issuer_pkg;
    localparam logic [1:0] PROCESS_SDIV  = 2'b00;
    localparam logic [1:0] PROCESS_SSQRT = 2'b01;
    localparam logic [1:0] PROCESS_DDIV  = 2'b10;
    localparam logic [1:0] PROCESS_DSQRT = 2'b11;
    localparam int PROC_SQRT_BIT = 0;
    localparam int PROC_DBL_BIT  = 1;
    localparam logic [31:0] QNAN_S = 32'h7FC0_0000;
    localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_Z, ACK_Z, OUT} state_e;
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  process;
    } req_t;
endpackage

// File: rtl/fp_operand_issuer_fifo.sv
// fp_issue_fifo: request FIFO with extra-wrap-bit pointers and combinational head read
module fp_issue_fifo
    import fp_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  req_t data_i,
    output req_t data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    req_t mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // a full FIFO refuses pushes even when the head leaves on the same edge
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/fp_operand_issuer.sv
// fp_operand_issuer: queues FP div/sqrt requests and drives them one at a time into Main;
// WAIT_Z watchdog enabled by FP_ISSUER_TIMEOUT_EN.
module fp_operand_issuer
    import fp_issuer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic [1:0]  in_process,
    output logic [1:0]  process,
    output logic [31:0] out_as,
    output logic [31:0] out_bs,
    output logic [63:0] out_ad,
    output logic [63:0] out_bd,
    output logic        out_a_stb,
    output logic        out_b_stb,
    input  logic        in_a_ack,
    input  logic        in_b_ack,
    input  logic        z_stb,
    output logic        z_ack,
    input  logic [31:0] zs,
    input  logic [63:0] zd,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic [1:0]  res_process,
    output logic        res_err,
    output logic        busy
);
    req_t head;
    logic full, empty, pop;
    state_e state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0] proc_q, proc_d;
    logic a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d;
`ifdef FP_ISSUER_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic err_q, err_d;
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif
    fp_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (in_valid),
        .pop_i  (pop),
        .data_i ('{a: in_a, b: in_b, process: in_process}),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );
    assign in_ready    = !full;
    assign busy        = (state_q != IDLE) || !empty;
    assign process     = proc_q;
    assign out_as      = a_q[31:0];
    assign out_bs      = b_q[31:0];
    assign out_ad      = a_q;
    assign out_bd      = b_q;
    assign out_a_stb   = a_stb_q;
    assign out_b_stb   = b_stb_q;
    assign z_ack       = z_ack_q;
    assign res_valid   = state_q == OUT;
    assign res_data    = res_q;
    assign res_process = proc_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        proc_d  = proc_q;
        res_d   = res_q;
        a_stb_d = a_stb_q;
        b_stb_d = b_stb_q;
        z_ack_d = z_ack_q;
        pop     = 1'b0;
`ifdef FP_ISSUER_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                a_d     = head.a;
                b_d     = head.b;
                proc_d  = head.process;
                a_stb_d = 1'b1;
                b_stb_d = !head.process[PROC_SQRT_BIT];
                state_d = SEND;
`ifdef FP_ISSUER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            SEND: begin
                a_stb_d = a_stb_q & ~in_a_ack;
                b_stb_d = b_stb_q & ~in_b_ack;
                state_d = (a_stb_d | b_stb_d) ? SEND : WAIT_Z;
            end
            WAIT_Z: if (z_stb) begin
                res_d   = proc_q[PROC_DBL_BIT] ? zd : {32'b0, zs};
                z_ack_d = 1'b1;
                state_d = ACK_Z;
            end
`ifdef FP_ISSUER_TIMEOUT_EN
            else if (cnt_q == 32'(TIMEOUT - 1)) begin
                res_d   = proc_q[PROC_DBL_BIT] ? QNAN_D : {32'b0, QNAN_S};
                err_d   = 1'b1;
                state_d = OUT;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
`endif
            ACK_Z: if (!z_stb) begin
                z_ack_d = 1'b0;
                state_d = OUT;
            end
            OUT: if (res_ready) begin
                state_d = IDLE;
`ifdef FP_ISSUER_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            proc_q  <= '0;
            res_q   <= '0;
            a_stb_q <= 1'b0;
            b_stb_q <= 1'b0;
            z_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            proc_q  <= proc_d;
            res_q   <= res_d;
            a_stb_q <= a_stb_d;
            b_stb_q <= b_stb_d;
            z_ack_q <= z_ack_d;
        end
    end
`ifdef FP_ISSUER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif
endmodule

// File: tb/tb_fp_operand_issuer.sv
// tb_fp_operand_issuer: directed vectors with the bench acting as Main on the stb/ack handshakes
module tb_fp_operand_issuer;
    import fp_issuer_pkg::*;
    logic clk = 1'b0, rst = 1'b0;
    logic in_valid, in_ready, in_a_ack, in_b_ack, z_stb, z_ack, res_valid, res_ready, res_err, busy;
    logic out_a_stb, out_b_stb;
    logic [63:0] in_a, in_b, out_ad, out_bd, zd, res_data;
    logic [31:0] out_as, out_bs, zs;
    logic [1:0] in_process, process, res_process;
    int n_chk = 0, n_fail = 0;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  p;
        logic [31:0] zs;
        logic [63:0] zd;
        logic        b_late;
        logic [63:0] exp;
    } vec_t;
    always #5 clk = ~clk;
    fp_operand_issuer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_process(in_process), .process(process), .out_as(out_as), .out_bs(out_bs),
        .out_ad(out_ad), .out_bd(out_bd), .out_a_stb(out_a_stb), .out_b_stb(out_b_stb),
        .in_a_ack(in_a_ack), .in_b_ack(in_b_ack), .z_stb(z_stb), .z_ack(z_ack), .zs(zs), .zd(zd),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_process(res_process), .res_err(res_err), .busy(busy)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_strobes"}, {out_a_stb, out_b_stb, z_ack, res_valid, res_err}, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_process"}, res_process, 0);
        chk({tag, "_process"}, process, 0);
        chk({tag, "_operands_d"}, out_ad | out_bd, 0);
        chk({tag, "_operands_s"}, {out_as, out_bs}, 0);
    endtask
    task automatic serve(input string nm, input logic [63:0] ea, input logic [1:0] ep,
                         input logic [31:0] zsv, input logic [63:0] zdv, input logic [63:0] er);
        int n;
        n = 0;
        while (!out_a_stb && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_issue"}, out_a_stb, 1);
        chk({nm, "_process"}, process, ep);
        chk({nm, "_out_ad"}, out_ad, ea);
        in_a_ack = 1'b1;
        in_b_ack = 1'b1;
        @(negedge clk);
        in_a_ack = 1'b0;
        in_b_ack = 1'b0;
        z_stb = 1'b1;
        zs = zsv;
        zd = zdv;
        @(negedge clk);
        chk({nm, "_z_ack"}, z_ack, 1);
        z_stb = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_res_valid"}, res_valid, 1);
        chk({nm, "_res_data"}, res_data, er);
        chk({nm, "_res_process"}, res_process, ep);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vec_t vt[4];
        logic [63:0] ra[5], rb[5], rzd[5], rexp[5];
        logic [31:0] rzs[5];
        logic [1:0] rp[5];
        logic seen;
        in_valid = 0; in_a = '0; in_b = '0; in_process = '0;
        in_a_ack = 0; in_b_ack = 0; z_stb = 0; zs = '0; zd = '0; res_ready = 0;
        vt[0] = '{a: 64'hFFFF_FFFF_3F80_0000, b: 64'h0000_0000_4000_0000, p: PROCESS_SDIV,
                  zs: 32'h3F00_0000, zd: 64'hDEAD_BEEF_DEAD_BEEF, b_late: 1'b0, exp: 64'h0000_0000_3F00_0000};
        vt[1] = '{a: 64'h0000_0000_4080_0000, b: 64'h1234_5678_9ABC_DEF0, p: PROCESS_SSQRT,
                  zs: 32'h4000_0000, zd: 64'hCAFE_F00D_CAFE_F00D, b_late: 1'b0, exp: 64'h0000_0000_4000_0000};
        vt[2] = '{a: 64'h4018_0000_0000_0000, b: 64'h4008_0000_0000_0000, p: PROCESS_DDIV,
                  zs: 32'h1111_1111, zd: 64'h4000_0000_0000_0000, b_late: 1'b1, exp: 64'h4000_0000_0000_0000};
        vt[3] = '{a: 64'h4010_0000_0000_0000, b: 64'h5555_0000_5555_0000, p: PROCESS_DSQRT,
                  zs: 32'h2222_2222, zd: 64'h4000_0000_0000_0001, b_late: 1'b0, exp: 64'h4000_0000_0000_0001};
        #2;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = vt[i].a; in_b = vt[i].b; in_process = vt[i].p;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_busy_queued", i), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d_a_stb", i), out_a_stb, 1);
            chk($sformatf("v%0d_b_stb", i), out_b_stb, !vt[i].p[0]);
            chk($sformatf("v%0d_process", i), process, vt[i].p);
            chk($sformatf("v%0d_out_as", i), out_as, vt[i].a[31:0]);
            chk($sformatf("v%0d_out_bs", i), out_bs, vt[i].b[31:0]);
            chk($sformatf("v%0d_out_ad", i), out_ad, vt[i].a);
            chk($sformatf("v%0d_out_bd", i), out_bd, vt[i].b);
            in_a_ack = 1'b1;
            in_b_ack = !vt[i].b_late;
            @(negedge clk);
            chk($sformatf("v%0d_a_retired", i), out_a_stb, 0);
            chk($sformatf("v%0d_b_after_a", i), out_b_stb, !vt[i].p[0] && vt[i].b_late);
            if (vt[i].b_late) begin
                in_a_ack = 1'b0;
                in_b_ack = 1'b1;
                @(negedge clk);
                chk($sformatf("v%0d_b_retired", i), out_b_stb, 0);
            end
            in_a_ack = 1'b0; in_b_ack = 1'b0;
            z_stb = 1'b1; zs = vt[i].zs; zd = vt[i].zd;
            @(negedge clk);
            chk($sformatf("v%0d_z_ack", i), z_ack, 1);
            chk($sformatf("v%0d_early_valid", i), res_valid, 0);
            chk($sformatf("v%0d_process_hold", i), process, vt[i].p);
            z_stb = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_z_ack_drop", i), z_ack, 0);
            chk($sformatf("v%0d_res_valid", i), res_valid, 1);
            chk($sformatf("v%0d_res_data", i), res_data, vt[i].exp);
            chk($sformatf("v%0d_res_process", i), res_process, vt[i].p);
            chk($sformatf("v%0d_res_err", i), res_err, 0);
            chk($sformatf("v%0d_operands_hold", i), out_ad ^ out_bd, vt[i].a ^ vt[i].b);
            @(negedge clk);
            chk($sformatf("v%0d_valid_held", i), res_valid, 1);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk($sformatf("v%0d_valid_drop", i), res_valid, 0);
            chk($sformatf("v%0d_idle", i), busy, 0);
        end
        for (int i = 0; i < 5; i++) begin
            ra[i] = 64'h4000_0000_0000_0010 + 64'(i);
            rb[i] = 64'(i * 3);
            rp[i] = 2'(i);
            rzs[i] = 32'hA000_0000 + 32'(i);
            rzd[i] = 64'hB000_0000_0000_0000 + 64'(i);
            rexp[i] = rp[i][1] ? rzd[i] : {32'b0, rzs[i]};
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_in_ready_%0d", i), in_ready, 1);
            in_valid = 1'b1; in_a = ra[i]; in_b = rb[i]; in_process = rp[i];
            @(negedge clk);
        end
        chk("bp_full", in_ready, 0);
        in_a = 64'hEEEE_EEEE_EEEE_EEEE; in_process = 2'b11;
        serve("bp_r0", ra[0], rp[0], rzs[0], rzd[0], rexp[0]);
        chk("bp_still_full", in_ready, 0);
        @(negedge clk);
        chk("bp_pop_frees", in_ready, 1);
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) serve($sformatf("bp_r%0d", i), ra[i], rp[i], rzs[i], rzd[i], rexp[i]);
        chk("bp_drained", busy, 0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | out_a_stb | res_valid;
        end
        chk("bp_no_extra", seen, 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = ra[i] ^ 64'hFF; in_b = rb[i]; in_process = 2'b11;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a_ack = 1'b1; in_b_ack = 1'b1;
        @(negedge clk);
        in_a_ack = 1'b0; in_b_ack = 1'b0;
        chk("rst_pre_busy", busy, 1);
        chk("rst_pre_process", process, 2'b11);
        #2 rst = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_a_stb | res_valid | z_ack | busy;
        end
        chk("rst_no_result", seen, 0);
`ifdef FP_ISSUER_TIMEOUT_EN
        in_valid = 1'b1; in_a = 64'h0000_0000_3F80_0000; in_b = 64'h0000_0000_4000_0000; in_process = PROCESS_SDIV;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("to_issue", out_a_stb, 1);
        in_a_ack = 1'b1; in_b_ack = 1'b1;
        @(negedge clk);
        in_a_ack = 1'b0; in_b_ack = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | res_valid;
        end
        chk("to_early", seen, 0);
        @(negedge clk);
        chk("to_valid", res_valid, 1);
        chk("to_err", res_err, 1);
        chk("to_nan", res_data, 64'h0000_0000_7FC0_0000);
        chk("to_no_z_ack", z_ack, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("to_err_clear", res_err, 0);
        chk("to_valid_drop", res_valid, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_operand_issuer.md
# fp_operand_issuer

Upstream issue stage for the floating-point divider/sqrt top (`Main`). It buffers operation requests (operands plus process code) in a small FIFO and drives them into `Main` over the stb/ack operand handshake. It then collects the result through the z_stb/z_ack handshake and returns it, tagged with its process code, on a valid/ready port. Exactly one operation is in flight in `Main` at any time.

## Interface

**Parameters**
- `DEPTH`, default 4: request FIFO depth; power of two, ≥2.
- `TIMEOUT`, default 4096: watchdog limit in cycles; used only with the timeout macro.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `in_a` in 64: operand a; singles use [31:0].
- `in_b` in 64: operand b; ignored for sqrt.
- `in_process` in 2: op code.
- `process` out 2: op code driven to `Main`.
- `out_as`, `out_bs` out 32: single operands (`a[31:0]`, `b[31:0]`).
- `out_ad`, `out_bd` out 64: double operands.
- `out_a_stb`, `out_b_stb` out 1: operand strobes.
- `in_a_ack`, `in_b_ack` in 1: operand acks from `Main`.
- `z_stb` in 1: result strobe from `Main`.
- `z_ack` out 1: result ack to `Main`.
- `zs` in 32: single result.
- `zd` in 64: double result.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer ready.
- `res_data` out 64: result; singles zero-extended.
- `res_process` out 2: op code of the result.
- `res_err` out 1: watchdog expiry flag.
- `busy` out 1: high when the FSM is not IDLE or the FIFO is non-empty.

## Operation

**Op codes**
- 00 single div, 01 single sqrt, 10 double div, 11 double sqrt.
- `process[0]=1` means sqrt; `process[1]=1` means double.

**FIFO**
- `in_ready = !full`.
- A push while full is blocked, even if a pop occurs in the same cycle.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.

**FSM**
- **IDLE**: if the FIFO is non-empty, pop, latch a/b/process into the operand registers, and go to SEND.
- **SEND**
  - `out_a_stb` is high until sampled together with `in_a_ack`, then low.
  - `out_b_stb` behaves the same way with `in_b_ack`, for div only. For sqrt, `out_b_stb` stays 0.
  - Strobes retire independently.
  - Go to WAIT_Z once all required strobes have retired.
- **WAIT_Z**: on `z_stb=1`, capture `zd` (double) or `{32'b0,zs}` (single) into `res_data`, assert `z_ack`, and go to ACK_Z.
- **ACK_Z**: hold `z_ack` until `z_stb` is sampled low, then deassert `z_ack` and go to OUT.
- **OUT**: `res_valid=1`; on `res_ready`, go to IDLE.

**Stability rules**
- `process` and the operand outputs change only on the IDLE pop.
- They are held stable from SEND through OUT.

**Reset**
- Applies at any state, including mid-handshake.
- FIFO is emptied and the FSM goes to IDLE.
- Reset values: all strobes/acks/valids 0, `res_data` 0, `res_process` 0, `res_err` 0, `process` 00, operand outputs 0, `in_ready` 1, `busy` 0.

## Timing

- Request accepted at edge k into an empty FIFO with FSM IDLE: pop at edge k+1; `out_a_stb` is high from k+1.
- A strobe drops on the edge after it is sampled with its ack.
- `z_ack` rises on the edge where `z_stb` is first sampled high.
- `res_valid` rises on the edge where `z_stb` is sampled low in ACK_Z.
- After `res_ready`, the next pop occurs at earliest 1 cycle after returning to IDLE. Minimum issue-to-issue overhead is 2 cycles beyond `Main` latency.
- Request enqueue overlaps any FSM state.

## Configuration

`FP_ISSUER_TIMEOUT_EN` defined:
- A watchdog counts cycles in WAIT_Z.
- At count = `TIMEOUT`, go to OUT with `res_err=1` and `res_data` = canonical quiet NaN: `7FC00000` zero-extended for single, `7FF8000000000000` for double.
- `z_ack` is not asserted.
- `res_err` clears on the OUT→IDLE transition.

`FP_ISSUER_TIMEOUT_EN` undefined:
- No counter; WAIT_Z waits indefinitely.
- `res_err` is tied to 0.

## Structure

- **Shared defines/package**
  - Op code constants (extend the existing `PROCESS_*` defines).
  - FSM state encoding: IDLE, SEND, WAIT_Z, ACK_Z, OUT.
  - Canonical NaN constants.
- **Sub-module** `fp_issue_fifo`
  - Parameterised by `DEPTH`.
  - Width 130 (a, b, process).
  - Combinational read of the head entry.

## Test plan

- Single div, a=3F800000, b=40000000 → `res_data`=000000003F000000, `res_process`=00.
- Single sqrt, a=40800000 → `res_data`=0000000040000000; `out_b_stb` never asserted.
- Double div, a=4018000000000000, b=4008000000000000 → `res_data`=4000000000000000; `process`=10 is stable throughout.
- Backpressure:
  - Push 5 requests with `res_ready`=0 and DEPTH=4.
  - `in_ready` drops after the 4th queued entry (plus one in flight).
  - Results return in push order once `res_ready`=1.
- Reset mid-operation: assert `rst`=0 in WAIT_Z with 2 entries queued → all outputs at reset values, `busy`=0, no later result emitted.
- With `FP_ISSUER_TIMEOUT_EN`, TIMEOUT=16, `z_stb` held 0 on a single div → after 16 cycles `res_valid`=1, `res_err`=1, `res_data`=000000007FC00000.
